// File: rtl/div_seq_pkg.sv
// Shared ALU divider definitions: operand width, FSM states and the
// quotient value reported on divide-by-zero.
package div_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  localparam logic [DATA_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_seq_if.sv
// Start/busy/done handshake and HI/LO result bus of the sequential divider.
interface div_seq_if;
  import div_seq_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] cHI;
  logic [DATA_W-1:0] cLOW;

  // Control unit side: issues divides, consumes results.
  modport master (
    output start, a, b,
    input  busy, done, div_by_zero, cHI, cLOW
  );

  // Divider side.
  modport slave (
    input  start, a, b,
    output busy, done, div_by_zero, cHI, cLOW
  );

endinterface

// File: rtl/div_seq_abs_neg.sv
// Combinational two's-complement conditional negate with one guard bit.
// With neg tied to the operand sign it yields the magnitude; the guard bit
// keeps |0x8000_0000| representable.
module abs_neg
  import div_seq_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic              neg,
  output logic [DATA_W:0]   y
);

  logic [DATA_W:0] ext;

  // Sign-extend, then negate on request.
  always_comb begin
    ext = {x[DATA_W-1], x};
    y   = neg ? (~ext + 1'b1) : ext;
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit signed restoring divider, one quotient bit per cycle.
// HI = remainder (sign follows dividend), LO = quotient (truncating).
module div_seq
  import div_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_seq_if.slave   bus
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [DATA_W-1:0]  chi_q, chi_d;
  logic [DATA_W-1:0]  clow_q, clow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  dvd_q, dvd_d;
  logic [DATA_W:0]    dvs_q, dvs_d;
  logic [DATA_W:0]    rem_q, rem_d;
  logic [DATA_W-1:0]  quo_q, quo_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;

  logic [DATA_W:0]    mag_a, mag_b, fix_quo, fix_rem;
  logic [DATA_W:0]    shifted;
  logic [DATA_W+1:0]  trial;
  logic               unused_bits;

  abs_neg u_mag_a (.x(bus.a),               .neg(bus.a[DATA_W-1]), .y(mag_a));
  abs_neg u_mag_b (.x(bus.b),               .neg(bus.b[DATA_W-1]), .y(mag_b));
  abs_neg u_fix_q (.x(quo_q),               .neg(sign_q_q),        .y(fix_quo));
  abs_neg u_fix_r (.x(rem_q[DATA_W-1:0]),   .neg(sign_r_q),        .y(fix_rem));

  // Remainder never exceeds |b| <= 2^31, so its top bit and the guard bits of
  // the fixup results are never needed.
  assign unused_bits = ^{fix_quo[DATA_W], fix_rem[DATA_W], rem_q[DATA_W]};

  // Next-state and datapath computation.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    chi_d    = chi_q;
    clow_d   = clow_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;

    shifted = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    trial   = {1'b0, shifted} - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is ignored.
        if (bus.start && !done_q) begin
          sign_q_d = bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
          sign_r_d = bus.a[DATA_W-1];
          dvd_d    = mag_a[DATA_W-1:0];
          dvs_d    = mag_b;
          quo_d    = '0;
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
          if (bus.b == '0) begin
            // Park |a| in the remainder so the sign fixup restores a into HI.
            rem_d   = mag_a;
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            rem_d   = '0;
            cnt_d   = CNT_W'(DATA_W - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
        if (!trial[DATA_W+1]) begin
          rem_d = trial[DATA_W:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        chi_d   = fix_rem[DATA_W-1:0];
        clow_d  = (dvs_q == '0) ? DIV_ZERO_QUOT : fix_quo[DATA_W-1:0];
        dbz_d   = (dvs_q == '0);
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      chi_q    <= '0;
      clow_q   <= '0;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      chi_q    <= chi_d;
      clow_q   <= clow_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.cHI         = chi_q;
  assign bus.cLOW        = clow_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: signed cases, overflow,
// divide-by-zero, busy/start handling, async reset and random operands.
module tb_div_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   lat;
  logic busy_at_start;
  bit   seen_done;

  div_seq_if bus ();

  div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count edges (from 1 already elapsed) until done, bounded.
  task automatic wait_done(inout int n);
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One divide: start sampled on the first edge, latency counted in edges.
  task automatic do_div(input logic [31:0] av, input logic [31:0] bv, output int n);
    @(posedge clk);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    busy_at_start = bus.busy;
    n = 1;
    wait_done(n);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_dbz",  32'(bus.div_by_zero), 32'd0);
    check("reset_chi",  bus.cHI, 32'd0);
    check("reset_clow", bus.cLOW, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7
    do_div(32'd100, 32'd7, lat);
    check("p_p_lat",  32'(lat), 32'd34);
    check("p_p_busy_start", 32'(busy_at_start), 32'd1);
    check("p_p_busy_done",  32'(bus.busy), 32'd0);
    check("p_p_quo",  bus.cLOW, 32'd14);
    check("p_p_rem",  bus.cHI, 32'd2);
    check("p_p_dbz",  32'(bus.div_by_zero), 32'd0);
    @(posedge clk); #1;
    check("done_pulse_one_cycle", 32'(bus.done), 32'd0);
    check("quo_held", bus.cLOW, 32'd14);

    // -100 / 7 and 100 / -7
    do_div(-32'sd100, 32'd7, lat);
    check("n_p_quo", bus.cLOW, 32'hFFFF_FFF2);
    check("n_p_rem", bus.cHI,  32'hFFFF_FFFE);
    do_div(32'd100, -32'sd7, lat);
    check("p_n_quo", bus.cLOW, 32'hFFFF_FFF2);
    check("p_n_rem", bus.cHI,  32'd2);

    // Overflow case
    do_div(32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("ovf_lat", 32'(lat), 32'd34);
    check("ovf_quo", bus.cLOW, 32'h8000_0000);
    check("ovf_rem", bus.cHI,  32'd0);
    check("ovf_dbz", 32'(bus.div_by_zero), 32'd0);

    // Divide by zero
    do_div(32'd55, 32'd0, lat);
    check("dbz_lat", 32'(lat), 32'd2);
    check("dbz_busy_start", 32'(busy_at_start), 32'd1);
    check("dbz_quo", bus.cLOW, 32'hFFFF_FFFF);
    check("dbz_rem", bus.cHI,  32'd55);
    check("dbz_flag", 32'(bus.div_by_zero), 32'd1);
    repeat (3) @(posedge clk); #1;
    check("dbz_flag_held", 32'(bus.div_by_zero), 32'd1);
    do_div(-32'sd55, 32'd0, lat);
    check("dbz_neg_rem", bus.cHI, 32'hFFFF_FFC9);

    // Second start while busy is ignored
    @(posedge clk);
    @(negedge clk);
    bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      bus.start = (lat == 10);
      if (lat == 10) begin
        bus.a = 32'd1;
        bus.b = 32'd1;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("busy_ign_lat", 32'(lat), 32'd34);
    check("busy_ign_quo", bus.cLOW, 32'd4);
    check("busy_ign_rem", bus.cHI,  32'd1);
    check("busy_ign_dbz_cleared", 32'(bus.div_by_zero), 32'd0);

    // start held through done: ignored in the done cycle, accepted next
    @(posedge clk);
    @(negedge clk);
    bus.a = 32'd20; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    wait_done(lat);
    check("held_lat",  32'(lat), 32'd34);
    check("held_quo",  bus.cLOW, 32'd6);
    @(posedge clk); #1;
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("start_after_done_accepted", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.a = 32'd7; bus.b = 32'd1;
    lat = 1;
    wait_done(lat);
    check("operand_change_lat", 32'(lat), 32'd34);
    check("operand_change_quo", bus.cLOW, 32'd6);
    check("operand_change_rem", bus.cHI,  32'd2);

    // Async reset mid-RUN
    @(posedge clk);
    @(negedge clk);
    bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_chi",  bus.cHI, 32'd0);
    check("rst_clow", bus.cLOW, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    do_div(32'd1000, 32'd3, lat);
    check("post_rst_lat", 32'(lat), 32'd34);
    check("post_rst_quo", bus.cLOW, 32'd333);
    check("post_rst_rem", bus.cHI,  32'd1);

    // Random signed operands against the language's truncating division
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb, eq, er;
      ra = $urandom;
      if (i % 2 == 0) rb = $urandom;
      else            rb = 32'($urandom_range(1, 1000));
      if (i % 3 == 0) rb = -rb;
      if (rb == '0) rb = 32'd5;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      eq = 32'($signed(ra) / $signed(rb));
      er = 32'($signed(ra) % $signed(rb));
      do_div(ra, rb, lat);
      check("rnd_lat", 32'(lat), 32'd34);
      check("rnd_quo", bus.cLOW, eq);
      check("rnd_rem", bus.cHI,  er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
